// File: rtl/gb_host_pkg.sv
// gb_host_pkg: shared FSM states and constants for ghostbus host-side masters.
package gb_host_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        RESP
    } gb_state_t;

    localparam int LAT_W = 4;

    localparam logic GB_WE_RST  = 1'b0;
    localparam logic GB_BUS_RST = 1'b0;

endpackage

// File: rtl/gb_lat_cnt.sv
// gb_lat_cnt: loadable down-counter; done is high in the cycle before it reaches zero.
module gb_lat_cnt
    import gb_host_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             done
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == LAT_W'(1));

endmodule

// File: rtl/gb_host_bridge.sv
// gb_host_bridge: valid/ready host requests to single ghostbus cycles, one in flight.
// Optional GB_HOST_RANGE_CHECK_EN answers addresses >= ADDR_LIMIT with rsp_err and no bus cycle.
module gb_host_bridge
    import gb_host_pkg::*;
#(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int RD_LAT     = 2,
    parameter int ADDR_LIMIT = 4096
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    input  logic [DW-1:0] gb_din,
    output logic          busy
);

    gb_state_t     state, state_d;
    logic          req_ready_d, rsp_valid_d, rsp_err_d, gb_we_d;
    logic [DW-1:0] rsp_rdata_d, gb_dout_d;
    logic [AW-1:0] gb_addr_d;
    logic          accept, addr_bad, lat_load, lat_done;

    assign accept = (state == IDLE) && req_valid && req_ready;

`ifdef GB_HOST_RANGE_CHECK_EN
    assign addr_bad = (32'(req_addr) >= 32'(ADDR_LIMIT));
`else
    logic unused_limit;
    assign unused_limit = (ADDR_LIMIT != 0);
    assign addr_bad     = 1'b0;
`endif

    gb_lat_cnt u_lat (
        .clk      (gb_clk),
        .rst_n    (gb_rst_n),
        .load     (lat_load),
        .load_val (LAT_W'(RD_LAT)),
        .done     (lat_done)
    );

    always_comb begin
        state_d     = state;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        gb_addr_d   = gb_addr;
        gb_dout_d   = gb_dout;
        gb_we_d     = 1'b0;
        lat_load    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (addr_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        gb_addr_d = req_addr;
                        gb_dout_d = req_wdata;
                        if (req_we) begin
                            state_d = WR;
                            gb_we_d = 1'b1;
                        end else begin
                            state_d  = RD_WAIT;
                            lat_load = 1'b1;
                        end
                    end
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RD_WAIT: begin
                // gb_din is valid at the root on the edge the counter expires
                if (lat_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = gb_din;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            gb_addr   <= {AW{GB_BUS_RST}};
            gb_dout   <= {DW{GB_BUS_RST}};
            gb_we     <= GB_WE_RST;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            gb_addr   <= gb_addr_d;
            gb_dout   <= gb_dout_d;
            gb_we     <= gb_we_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule
